// File: rtl/para_sram_arbiter_if.sv
// Requester and SRAM-side bus of the parallel SRAM arbiter.
// slave = arbiter view, master = requesters + SRAM view.
interface para_sram_arbiter_if #(
  parameter int NUM_REQ      = 2,
  parameter int NUM_PARALLEL = 6,
  parameter int ADDR_W       = 13,
  parameter int DATA_W       = 24,
  parameter int BANK_W       = 3
);
  logic [NUM_REQ-1:0]                   i_req_valid;
  logic [NUM_REQ-1:0]                   i_req_we;
  logic [NUM_REQ-1:0][BANK_W-1:0]       i_req_bank;
  logic [NUM_REQ-1:0][ADDR_W-1:0]       i_req_addr;
  logic [NUM_REQ-1:0][DATA_W-1:0]       i_req_wdata;
  logic [NUM_REQ-1:0]                   o_req_gnt;
  logic [NUM_REQ-1:0]                   o_rvalid;
  logic [NUM_REQ-1:0][DATA_W-1:0]       o_rdata;
  logic [NUM_PARALLEL-1:0]              o_write_en;
  logic [NUM_PARALLEL-1:0][ADDR_W-1:0]  o_write_address;
  logic [NUM_PARALLEL-1:0][DATA_W-1:0]  o_write_data;
  logic [NUM_PARALLEL-1:0][ADDR_W-1:0]  o_read_address;
  logic [NUM_PARALLEL-1:0][DATA_W-1:0]  i_read_data;

  modport slave (
    input  i_req_valid, i_req_we, i_req_bank,
    input  i_req_addr, i_req_wdata, i_read_data,
    output o_req_gnt, o_rvalid, o_rdata,
    output o_write_en, o_write_address,
    output o_write_data, o_read_address
  );

  modport master (
    output i_req_valid, i_req_we, i_req_bank,
    output i_req_addr, i_req_wdata, i_read_data,
    input  o_req_gnt, o_rvalid, o_rdata,
    input  o_write_en, o_write_address,
    input  o_write_data, o_read_address
  );
endinterface

// File: rtl/para_sram_arbiter.sv
// Per-bank round-robin write/read arbiter for a banked parallel SRAM.
// Define PARA_SRAM_ARB_BYPASS_EN to forward same-cycle write data to reads.
module para_sram_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int NUM_PARALLEL = 6,
  parameter int ADDR_W       = 13,
  parameter int DATA_W       = 24,
  parameter int SRAM_LAT     = 1,
  parameter int BANK_W       = 3
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  para_sram_arbiter_if.slave bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int DEPTH = 1 + SRAM_LAT;

  function automatic int wrap(input int p, input int k);
    int s;
    s = p + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return s;
  endfunction

  logic [NUM_PARALLEL-1:0][PTR_W-1:0] wptr;
  logic [NUM_PARALLEL-1:0][PTR_W-1:0] rptr;
  logic [NUM_PARALLEL-1:0][PTR_W-1:0] wwin;
  logic [NUM_PARALLEL-1:0][PTR_W-1:0] rwin;
  logic [NUM_PARALLEL-1:0]            wgnt_any;
  logic [NUM_PARALLEL-1:0]            rgnt_any;
  logic [NUM_REQ-1:0]                 bad;
  logic [NUM_REQ-1:0]                 gnt_raw;
  logic [NUM_REQ-1:0]                 gnt;
  logic [NUM_REQ-1:0]                 rd_gnt;

  logic [DEPTH-1:0][NUM_REQ-1:0]             tag_v;
  logic [DEPTH-1:0][NUM_REQ-1:0]             tag_bad;
  logic [DEPTH-1:0][NUM_REQ-1:0][BANK_W-1:0] tag_bank;

  // Out-of-range banks are accepted at once and never reach the SRAM.
  always_comb begin
    bad      = '0;
    gnt_raw  = '0;
    wgnt_any = '0;
    rgnt_any = '0;
    wwin     = '0;
    rwin     = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      bad[r] = int'(bus.i_req_bank[r]) >= NUM_PARALLEL;
      if (bus.i_req_valid[r] && bad[r]) gnt_raw[r] = 1'b1;
    end
    for (int b = 0; b < NUM_PARALLEL; b++) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        for (int r = 0; r < NUM_REQ; r++) begin
          if (r == wrap(int'(wptr[b]), k) && !wgnt_any[b] &&
              bus.i_req_valid[r] && bus.i_req_we[r] && !bad[r] &&
              bus.i_req_bank[r] == BANK_W'(b)) begin
            wgnt_any[b] = 1'b1;
            wwin[b]     = PTR_W'(r);
            gnt_raw[r]  = 1'b1;
          end
          if (r == wrap(int'(rptr[b]), k) && !rgnt_any[b] &&
              bus.i_req_valid[r] && !bus.i_req_we[r] && !bad[r] &&
              bus.i_req_bank[r] == BANK_W'(b)) begin
            rgnt_any[b] = 1'b1;
            rwin[b]     = PTR_W'(r);
            gnt_raw[r]  = 1'b1;
          end
        end
      end
    end
  end

  assign gnt           = gnt_raw & {NUM_REQ{i_rst_n}};
  assign rd_gnt        = gnt & ~bus.i_req_we;
  assign bus.o_req_gnt = gnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      for (int b = 0; b < NUM_PARALLEL; b++) begin
        if (wgnt_any[b])
          wptr[b] <= PTR_W'(wrap(int'(wwin[b]), 1));
        if (rgnt_any[b])
          rptr[b] <= PTR_W'(wrap(int'(rwin[b]), 1));
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bus.o_write_en      <= '0;
      bus.o_write_address <= '0;
      bus.o_write_data    <= '0;
      bus.o_read_address  <= '0;
    end else begin
      for (int b = 0; b < NUM_PARALLEL; b++) begin
        bus.o_write_en[b] <= wgnt_any[b];
        if (wgnt_any[b]) begin
          bus.o_write_address[b] <= bus.i_req_addr[wwin[b]];
          bus.o_write_data[b]    <= bus.i_req_wdata[wwin[b]];
        end
        if (rgnt_any[b])
          bus.o_read_address[b] <= bus.i_req_addr[rwin[b]];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tag_v    <= '0;
      tag_bad  <= '0;
      tag_bank <= '0;
    end else begin
      tag_v[0]    <= rd_gnt;
      tag_bad[0]  <= bad;
      tag_bank[0] <= bus.i_req_bank;
      for (int s = 1; s < DEPTH; s++) begin
        tag_v[s]    <= tag_v[s-1];
        tag_bad[s]  <= tag_bad[s-1];
        tag_bank[s] <= tag_bank[s-1];
      end
    end
  end

`ifdef PARA_SRAM_ARB_BYPASS_EN
  logic [NUM_REQ-1:0]                        byp;
  logic [NUM_REQ-1:0][DATA_W-1:0]            byp_data;
  logic [DEPTH-1:0][NUM_REQ-1:0]             tag_byp;
  logic [DEPTH-1:0][NUM_REQ-1:0][DATA_W-1:0] tag_bdata;

  always_comb begin
    byp      = '0;
    byp_data = '0;
    for (int b = 0; b < NUM_PARALLEL; b++) begin
      for (int r = 0; r < NUM_REQ; r++) begin
        if (wgnt_any[b] && rgnt_any[b] && rwin[b] == PTR_W'(r) &&
            bus.i_req_addr[wwin[b]] == bus.i_req_addr[rwin[b]]) begin
          byp[r]      = 1'b1;
          byp_data[r] = bus.i_req_wdata[wwin[b]];
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tag_byp   <= '0;
      tag_bdata <= '0;
    end else begin
      tag_byp[0]   <= byp;
      tag_bdata[0] <= byp_data;
      for (int s = 1; s < DEPTH; s++) begin
        tag_byp[s]   <= tag_byp[s-1];
        tag_bdata[s] <= tag_bdata[s-1];
      end
    end
  end
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bus.o_rvalid <= '0;
      bus.o_rdata  <= '0;
    end else begin
      for (int r = 0; r < NUM_REQ; r++) begin
        bus.o_rvalid[r] <= tag_v[DEPTH-1][r];
        if (tag_v[DEPTH-1][r]) begin
          if (tag_bad[DEPTH-1][r])
            bus.o_rdata[r] <= '0;
`ifdef PARA_SRAM_ARB_BYPASS_EN
          else if (tag_byp[DEPTH-1][r])
            bus.o_rdata[r] <= tag_bdata[DEPTH-1][r];
`endif
          else
            bus.o_rdata[r] <= bus.i_read_data[tag_bank[DEPTH-1][r]];
        end
      end
    end
  end

endmodule

// File: tb/tb_para_sram_arbiter.sv
// Directed + random bench for para_sram_arbiter with a queue-based model.
// Honors PARA_SRAM_ARB_BYPASS_EN for same-address read/write expectations.
module tb_para_sram_arbiter;
  localparam int NR  = 2;
  localparam int NP  = 6;
  localparam int AW  = 13;
  localparam int DW  = 24;
  localparam int BW  = 3;
  localparam int LAT = 1;

  logic clk = 1'b0;
  logic rst_n;
  logic mem_clr;
  always #5 clk = ~clk;

  para_sram_arbiter_if #(
    .NUM_REQ(NR), .NUM_PARALLEL(NP), .ADDR_W(AW),
    .DATA_W(DW), .BANK_W(BW)
  ) bus ();

  para_sram_arbiter #(
    .NUM_REQ(NR), .NUM_PARALLEL(NP), .ADDR_W(AW),
    .DATA_W(DW), .SRAM_LAT(LAT), .BANK_W(BW)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .bus(bus)
  );

  // SRAM: one-cycle read, read-before-write on a shared address
  logic [DW-1:0]          mem [NP][64];
  logic [NP-1:0][DW-1:0]  rdq;
  assign bus.i_read_data = rdq;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int b = 0; b < NP; b++)
        for (int a = 0; a < 64; a++) mem[b][a] <= '0;
      rdq <= '0;
    end else begin
      for (int b = 0; b < NP; b++) begin
        rdq[b] <= mem[b][bus.o_read_address[b][5:0]];
        if (bus.o_write_en[b])
          mem[b][bus.o_write_address[b][5:0]] <= bus.o_write_data[b];
      end
    end
  end

  typedef struct {
    int          due;
    logic [DW-1:0] data;
  } rq_t;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic          pv    [NR];
  logic          pwe   [NR];
  logic [BW-1:0] pbank [NR];
  logic [AW-1:0] paddr [NR];
  logic [DW-1:0] pdata [NR];

  int            wptr [NP];
  int            rptr [NP];
  logic [DW-1:0] ref_mem [NP][64];
  rq_t           rq [NR][$];
  logic [NP-1:0]         exp_we;
  logic [NP-1:0][AW-1:0] exp_waddr;
  logic [NP-1:0][DW-1:0] exp_wdata;
  logic [NP-1:0][AW-1:0] exp_raddr;
  logic [NR-1:0]         last_mg;

  logic [NR-1:0]         obs_gnt;
  logic [NR-1:0]         obs_rv;
  logic [NR-1:0][DW-1:0] obs_rd;
  logic [NP-1:0]         obs_we;
  logic [NP-1:0][AW-1:0] obs_waddr;
  logic [NP-1:0][DW-1:0] obs_wdata;
  logic [NP-1:0][AW-1:0] obs_raddr;

  task automatic chk(input string tag, input logic [159:0] obs,
                     input logic [159:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic req(input int r, input logic v, input logic we,
                     input int bank, input int addr, input int data);
    pv[r]    = v;
    pwe[r]   = we;
    pbank[r] = BW'(bank);
    paddr[r] = AW'(addr);
    pdata[r] = DW'(data);
  endtask

  task automatic idle();
    for (int r = 0; r < NR; r++) req(r, 1'b0, 1'b0, 0, 0, 0);
  endtask

  task automatic drive();
    for (int r = 0; r < NR; r++) begin
      bus.i_req_valid[r] = pv[r];
      bus.i_req_we[r]    = pwe[r];
      bus.i_req_bank[r]  = pbank[r];
      bus.i_req_addr[r]  = paddr[r];
      bus.i_req_wdata[r] = pdata[r];
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < NP; b++) begin
      wptr[b] = 0;
      rptr[b] = 0;
    end
    for (int r = 0; r < NR; r++) rq[r].delete();
    exp_we    = '0;
    exp_waddr = '0;
    exp_wdata = '0;
    exp_raddr = '0;
  endtask

  // One clock: drive, check mid-cycle against the model, advance the model.
  task automatic step();
    logic [NR-1:0]         mg;
    logic [NR-1:0]         ev;
    logic [NR-1:0][DW-1:0] ed;
    int ww [NP];
    int rw [NP];
    drive();
    #3;
    mg = '0;
    for (int r = 0; r < NR; r++)
      if (pv[r] && int'(pbank[r]) >= NP) mg[r] = 1'b1;
    for (int b = 0; b < NP; b++) begin
      ww[b] = -1;
      rw[b] = -1;
      for (int k = 0; k < NR; k++) begin
        int r1;
        int r2;
        r1 = (wptr[b] + k) % NR;
        r2 = (rptr[b] + k) % NR;
        if (ww[b] < 0 && pv[r1] && pwe[r1] && int'(pbank[r1]) == b)
          ww[b] = r1;
        if (rw[b] < 0 && pv[r2] && !pwe[r2] && int'(pbank[r2]) == b)
          rw[b] = r2;
      end
      if (ww[b] >= 0) mg[ww[b]] = 1'b1;
      if (rw[b] >= 0) mg[rw[b]] = 1'b1;
    end
    chk("gnt", bus.o_req_gnt, mg);
    chk("write_en", bus.o_write_en, exp_we);
    chk("write_address", bus.o_write_address, exp_waddr);
    chk("write_data", bus.o_write_data, exp_wdata);
    chk("read_address", bus.o_read_address, exp_raddr);
    ev = '0;
    ed = '0;
    for (int r = 0; r < NR; r++)
      if (rq[r].size() > 0 && rq[r][0].due == cyc) begin
        ev[r] = 1'b1;
        ed[r] = rq[r][0].data;
        void'(rq[r].pop_front());
      end
    chk("rvalid", bus.o_rvalid, ev);
    for (int r = 0; r < NR; r++)
      if (ev[r]) chk("rdata", bus.o_rdata[r], ed[r]);
    obs_gnt   = bus.o_req_gnt;
    obs_rv    = bus.o_rvalid;
    obs_rd    = bus.o_rdata;
    obs_we    = bus.o_write_en;
    obs_waddr = bus.o_write_address;
    obs_wdata = bus.o_write_data;
    obs_raddr = bus.o_read_address;
    for (int r = 0; r < NR; r++)
      if (mg[r] && !pwe[r]) begin
        rq_t e;
        e.due = cyc + 2 + LAT;
        if (int'(pbank[r]) >= NP) e.data = '0;
        else e.data = ref_mem[pbank[r]][paddr[r][5:0]];
`ifdef PARA_SRAM_ARB_BYPASS_EN
        if (int'(pbank[r]) < NP && ww[pbank[r]] >= 0 &&
            paddr[ww[pbank[r]]] == paddr[r])
          e.data = pdata[ww[pbank[r]]];
`endif
        rq[r].push_back(e);
      end
    exp_we = '0;
    for (int b = 0; b < NP; b++) begin
      if (ww[b] >= 0) begin
        exp_we[b]    = 1'b1;
        exp_waddr[b] = paddr[ww[b]];
        exp_wdata[b] = pdata[ww[b]];
        wptr[b]      = (ww[b] + 1) % NR;
        ref_mem[b][paddr[ww[b]][5:0]] = pdata[ww[b]];
      end
      if (rw[b] >= 0) begin
        exp_raddr[b] = paddr[rw[b]];
        rptr[b]      = (rw[b] + 1) % NR;
      end
    end
    last_mg = mg;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic reset_pulse();
    drive();
    rst_n = 1'b0;
    #3;
    chk("rst_gnt", bus.o_req_gnt, '0);
    chk("rst_write_en", bus.o_write_en, '0);
    chk("rst_rvalid", bus.o_rvalid, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    cyc++;
  endtask

  initial begin
    rst_n   = 1'b0;
    mem_clr = 1'b1;
    for (int b = 0; b < NP; b++)
      for (int a = 0; a < 64; a++) ref_mem[b][a] = '0;
    model_reset();
    last_mg = '0;
    idle();
    req(0, 1'b1, 1'b1, 0, 3, 9);
    req(1, 1'b1, 1'b0, 1, 3, 0);
    drive();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_gnt", bus.o_req_gnt, '0);
    chk("reset_rvalid", bus.o_rvalid, '0);
    chk("reset_rdata", bus.o_rdata, '0);
    chk("reset_write_en", bus.o_write_en, '0);
    chk("reset_waddr", bus.o_write_address, '0);
    chk("reset_wdata", bus.o_write_data, '0);
    chk("reset_raddr", bus.o_read_address, '0);
    idle();
    drive();
    mem_clr = 1'b0;
    rst_n   = 1'b1;
    @(posedge clk);
    #1;

    // same-bank writes from both requesters
    req(0, 1'b1, 1'b1, 2, 3, 'h111);
    req(1, 1'b1, 1'b1, 2, 4, 'h222);
    step();
    chk("t1_gnt_first", obs_gnt, 2'b01);
    req(0, 1'b0, 1'b0, 0, 0, 0);
    step();
    chk("t1_gnt_second", obs_gnt, 2'b10);
    chk("t1_we_a", obs_we[2], 1'b1);
    chk("t1_wdata_a", obs_wdata[2], 24'h111);
    idle();
    step();
    chk("t1_we_b", obs_we[2], 1'b1);
    chk("t1_wdata_b", obs_wdata[2], 24'h222);
    step();

    // write then read back
    req(0, 1'b1, 1'b1, 0, 41, 50);
    step();
    idle();
    step();
    req(1, 1'b1, 1'b0, 0, 41, 0);
    step();
    idle();
    repeat (3) step();
    chk("t2_rvalid", obs_rv[1], 1'b1);
    chk("t2_rdata", obs_rd[1], 24'd50);

    // write and read on different banks together
    req(0, 1'b1, 1'b1, 1, 56, 100);
    req(1, 1'b1, 1'b0, 3, 10, 0);
    step();
    chk("t3_gnt", obs_gnt, 2'b11);
    idle();
    step();
    chk("t3_we", obs_we[1], 1'b1);
    chk("t3_waddr", obs_waddr[1], 13'd56);
    chk("t3_raddr", obs_raddr[3], 13'd10);
    repeat (2) step();

    // same bank, same address, read and write together
    req(0, 1'b1, 1'b1, 4, 5, 7);
    step();
    idle();
    step();
    req(0, 1'b1, 1'b0, 4, 5, 0);
    req(1, 1'b1, 1'b1, 4, 5, 40);
    step();
    chk("t4_gnt", obs_gnt, 2'b11);
    idle();
    repeat (3) step();
    chk("t4_rvalid", obs_rv[0], 1'b1);
`ifdef PARA_SRAM_ARB_BYPASS_EN
    chk("t4_rdata", obs_rd[0], 24'd40);
`else
    chk("t4_rdata", obs_rd[0], 24'd7);
`endif

    // invalid bank read
    req(1, 1'b1, 1'b0, 7, 0, 0);
    step();
    chk("t5_gnt", obs_gnt, 2'b10);
    idle();
    repeat (3) step();
    chk("t5_rvalid", obs_rv[1], 1'b1);
    chk("t5_rdata", obs_rd[1], 24'd0);

    // randomized traffic, requests held until granted
    for (int n = 0; n < 400; n++) begin
      for (int r = 0; r < NR; r++) begin
        if (!pv[r] || last_mg[r]) begin
          req(r, ($urandom % 4) != 0, $urandom % 2,
              $urandom_range(0, 7), $urandom_range(0, 31),
              $urandom & 32'hFFFFFF);
        end else if ($urandom % 16 == 0) begin
          pv[r] = 1'b0;
        end
      end
      step();
    end
    idle();
    repeat (4) step();

    // reset flushes an in-flight read and the pointers
    req(0, 1'b1, 1'b1, 2, 9, 5);
    step();
    idle();
    req(1, 1'b1, 1'b0, 3, 10, 0);
    step();
    chk("t6_read_gnt", obs_gnt, 2'b10);
    idle();
    req(0, 1'b1, 1'b0, 5, 1, 0);
    reset_pulse();
    idle();
    step();
    step();
    chk("t6_no_rvalid", obs_rv, 2'b00);
    req(0, 1'b1, 1'b1, 2, 1, 1);
    req(1, 1'b1, 1'b1, 2, 2, 2);
    step();
    chk("t6_first_gnt", obs_gnt, 2'b01);
    req(0, 1'b0, 1'b0, 0, 0, 0);
    step();
    idle();
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
